// File: rtl/ebpc_pkg.sv
// Shared EBPC encoder types: token kinds, plane-sequencer states and default widths.
package ebpc_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int MAX_ZRL_DEF = 16;
    localparam int IDX_W       = $clog2(DATA_W_DEF + 1);
    localparam int LEN_W       = $clog2(MAX_ZRL_DEF + 1);

    typedef enum logic [1:0] {
        TOK_BASE  = 2'd0,
        TOK_ZRL   = 2'd1,
        TOK_PLANE = 2'd2
    } tok_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BASE = 2'd1,
        ST_SCAN = 2'd2
    } state_e;

endpackage

// File: rtl/dbx_plane_sequencer_if.sv
// Token stream from the plane sequencer to the plane symbol encoder (valid/ready).
interface dbx_plane_sequencer_if #(
    parameter int BLOCK_SIZE = 8,
    parameter int DATA_W     = 32,
    parameter int MAX_ZRL    = 16
);
    import ebpc_pkg::*;

    localparam int IW = $clog2(DATA_W + 1);
    localparam int LW = $clog2(MAX_ZRL + 1);

    logic                  vld;
    logic                  rdy;
    tok_type_e             tok_type;
    logic [DATA_W-1:0]     tok_base;
    logic [BLOCK_SIZE-2:0] tok_dbx;
    logic [BLOCK_SIZE-2:0] tok_dbp;
    logic [IW-1:0]         tok_idx;
    logic [LW-1:0]         tok_len;
    logic                  tok_last;

    modport master (
        output vld, tok_type, tok_base, tok_dbx, tok_dbp, tok_idx, tok_len, tok_last,
        input  rdy
    );

    modport slave (
        input  vld, tok_type, tok_base, tok_dbx, tok_dbp, tok_idx, tok_len, tok_last,
        output rdy
    );

endinterface

// File: rtl/dbx_plane_sequencer.sv
// Walks one held block from the MSB plane down, emitting BASE, PLANE and zero-run tokens.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no block; outputs quiet, waits for vld_i
// BASE    | presenting the base-value token
// SCAN    | evaluating dbx_i[idx_q]: accumulate zeros, or emit ZRL/PLANE
module dbx_plane_sequencer
    import ebpc_pkg::*;
#(
    parameter int BLOCK_SIZE = 8,
    parameter int DATA_W     = 32,
    parameter int MAX_ZRL    = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [0:DATA_W][BLOCK_SIZE-2:0]     dbp_i,
    input  logic [0:DATA_W][BLOCK_SIZE-2:0]     dbx_i,
    input  logic [DATA_W-1:0]                   base_i,
    input  logic                                vld_i,
    output logic                                rdy_o,
    dbx_plane_sequencer_if.master               tok
);

    localparam int IW = $clog2(DATA_W + 1);
    localparam int LW = $clog2(MAX_ZRL + 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [LW-1:0] zrl_q, zrl_d;
    logic          plane_zero;
    logic          idx_at_0;
    logic          run_full;

    assign plane_zero = ~|dbx_i[idx_q];
    assign idx_at_0   = (idx_q == '0);
    assign run_full   = (int'(zrl_q) + 1) >= MAX_ZRL;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= IW'(DATA_W);
            zrl_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            zrl_q   <= zrl_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        zrl_d        = zrl_q;
        rdy_o        = 1'b0;
        tok.vld      = 1'b0;
        tok.tok_type = TOK_BASE;
        tok.tok_base = '0;
        tok.tok_dbx  = '0;
        tok.tok_dbp  = '0;
        tok.tok_idx  = '0;
        tok.tok_len  = '0;
        tok.tok_last = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (vld_i) state_d = ST_BASE;
            end

            ST_BASE: begin
                tok.vld      = 1'b1;
                tok.tok_base = base_i;
                if (tok.rdy) begin
                    idx_d   = IW'(DATA_W);
                    zrl_d   = '0;
                    state_d = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (plane_zero && !run_full && !idx_at_0) begin
                    // silent accumulate: no token, so rdy is irrelevant here
                    zrl_d = zrl_q + LW'(1);
                    idx_d = idx_q - IW'(1);
                end else if (plane_zero) begin
                    tok.vld      = 1'b1;
                    tok.tok_type = TOK_ZRL;
                    tok.tok_len  = zrl_q + LW'(1);
                    tok.tok_last = idx_at_0;
                    if (tok.rdy) begin
                        zrl_d = '0;
                        if (idx_at_0) begin
                            rdy_o   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            idx_d = idx_q - IW'(1);
                        end
                    end
                end else if (zrl_q != '0) begin
                    // flush the pending run; the nonzero plane is taken next cycle
                    tok.vld      = 1'b1;
                    tok.tok_type = TOK_ZRL;
                    tok.tok_len  = zrl_q;
                    if (tok.rdy) zrl_d = '0;
                end else begin
                    tok.vld      = 1'b1;
                    tok.tok_type = TOK_PLANE;
                    tok.tok_dbx  = dbx_i[idx_q];
                    tok.tok_dbp  = dbp_i[idx_q];
                    tok.tok_idx  = idx_q;
                    tok.tok_last = idx_at_0;
                    if (tok.rdy) begin
                        if (idx_at_0) begin
                            rdy_o   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            idx_d = idx_q - IW'(1);
                        end
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dbx_plane_sequencer.sv
// Random and directed blocks on two sequencers (MAX_ZRL 16 and 4) against a token-list model.
module tb_dbx_plane_sequencer;
    import ebpc_pkg::*;

    localparam int BS = 8;
    localparam int DW = 8;
    localparam int TW = 34;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic [0:DW][BS-2:0] dbp, dbx;
    logic [DW-1:0] base;
    logic vld_s [2];
    logic rdy_s [2];
    logic rdyo_a, rdyo_b;
    logic rdyo [2];
    logic vldo [2];
    logic [TW-1:0] tokv [2];

    int n_chk = 0;
    int n_pass = 0;
    logic [TW-1:0] exp_q [$];

    always #5 clk = ~clk;

    dbx_plane_sequencer_if #(.BLOCK_SIZE(BS), .DATA_W(DW), .MAX_ZRL(16)) if_a ();
    dbx_plane_sequencer_if #(.BLOCK_SIZE(BS), .DATA_W(DW), .MAX_ZRL(4))  if_b ();

    dbx_plane_sequencer #(.BLOCK_SIZE(BS), .DATA_W(DW), .MAX_ZRL(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .dbp_i(dbp), .dbx_i(dbx), .base_i(base),
        .vld_i(vld_s[0]), .rdy_o(rdyo_a), .tok(if_a.master));

    dbx_plane_sequencer #(.BLOCK_SIZE(BS), .DATA_W(DW), .MAX_ZRL(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .dbp_i(dbp), .dbx_i(dbx), .base_i(base),
        .vld_i(vld_s[1]), .rdy_o(rdyo_b), .tok(if_b.master));

    assign if_a.rdy = rdy_s[0];
    assign if_b.rdy = rdy_s[1];

    always_comb begin
        rdyo[0] = rdyo_a;
        rdyo[1] = rdyo_b;
        vldo[0] = if_a.vld;
        vldo[1] = if_b.vld;
        tokv[0] = {if_a.tok_type, if_a.tok_base, if_a.tok_dbx, if_a.tok_dbp,
                   if_a.tok_idx, if_a.tok_len, if_a.tok_last};
        tokv[1] = {if_b.tok_type, if_b.tok_base, if_b.tok_dbx, if_b.tok_dbp,
                   if_b.tok_idx, 2'b00, if_b.tok_len, if_b.tok_last};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [TW-1:0] mk(input logic [1:0] t, input logic [7:0] b,
                                         input logic [6:0] x, input logic [6:0] p,
                                         input logic [3:0] i, input logic [4:0] l);
        return {t, b, x, p, i, l, 1'b0};
    endfunction

    // Expected token list: runs of zero planes become ZRL tokens, capped at mz.
    task automatic build_exp(input int mz, output int splits);
        int run;
        logic [TW-1:0] t;
        exp_q.delete();
        splits = 0;
        run = 0;
        exp_q.push_back(mk(2'd0, base, 7'd0, 7'd0, 4'd0, 5'd0));
        for (int i = DW; i >= 0; i--) begin
            if (dbx[i] == '0) begin
                run++;
                if (run == mz) begin
                    exp_q.push_back(mk(2'd1, 8'd0, 7'd0, 7'd0, 4'd0, 5'(run)));
                    run = 0;
                end
            end else begin
                if (run > 0) begin
                    exp_q.push_back(mk(2'd1, 8'd0, 7'd0, 7'd0, 4'd0, 5'(run)));
                    splits++;
                    run = 0;
                end
                exp_q.push_back(mk(2'd2, 8'd0, dbx[i], dbp[i], 4'(i), 5'd0));
            end
        end
        if (run > 0) exp_q.push_back(mk(2'd1, 8'd0, 7'd0, 7'd0, 4'd0, 5'(run)));
        t = exp_q.pop_back();
        t[0] = 1'b1;
        exp_q.push_back(t);
    endtask

    // Called at a falling edge; returns at a falling edge. mode 0: rdy=1, 1: random rdy,
    // 2: hold rdy low 3 cycles on PLANE idx 5. abort_idx>=0 resets on seeing PLANE idx.
    task automatic run_block(input int s, input int mode, input int abort_idx);
        int splits, n, stall_cnt;
        bit done, seen, holding, r, hs;
        logic [TW-1:0] held, e;
        build_exp((s == 0) ? 16 : 4, splits);
        vld_s[s] = 1'b1;
        vld_s[1-s] = 1'b0;
        n = 0; stall_cnt = 0; done = 0; seen = 0; holding = 0;
        while (!done && n < 300) begin
            #1;
            if (holding) check("stall_hold", tokv[s], held);
            holding = 0;
            if (!vldo[s]) check("quiet_out", tokv[s], '0);
            if (abort_idx >= 0 && vldo[s] && tokv[s][33:32] == 2'd2 &&
                int'(tokv[s][9:6]) == abort_idx) begin
                rst_ni = 1'b0;
                #1;
                check("rst_vld", vldo[s], 0);
                check("rst_rdy", rdyo[s], 0);
                check("rst_tok", tokv[s], '0);
                @(posedge clk);
                #1;
                check("rst_hold_vld", vldo[s], 0);
                @(negedge clk);
                rst_ni = 1'b1;
                return;
            end
            if (mode == 0) r = 1;
            else if (mode == 1) r = ($urandom_range(0, 2) != 0);
            else if (vldo[s] && tokv[s][33:32] == 2'd2 && tokv[s][9:6] == 4'd5 && stall_cnt < 3) begin
                r = 0;
                stall_cnt++;
            end else r = 1;
            rdy_s[s] = r;
            #1;
            hs = vldo[s] && r;
            if (vldo[s] && !seen) begin
                seen = 1;
                check("latency", n, 1);
            end
            if (vldo[s] && !r) begin
                holding = 1;
                held = tokv[s];
            end
            if (hs) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                check("tok", tokv[s], e);
                check("rdy_o_pulse", rdyo[s], e[0]);
                if (e[0]) begin
                    done = 1;
                    if (mode == 0) check("cycles", n, 2 + DW + splits);
                end
            end else begin
                check("rdy_o_quiet", rdyo[s], 0);
            end
            @(negedge clk);
            n++;
        end
        check("blk_done", done, 1);
        check("tok_left", exp_q.size(), 0);
        if (mode == 2) check("stall_cnt", stall_cnt, 3);
        vld_s[s] = 1'b0;
    endtask

    task automatic rand_planes(input int zero_pct);
        for (int i = 0; i <= DW; i++) begin
            dbp[i] = 7'($urandom);
            dbx[i] = ($urandom_range(0, 99) < zero_pct) ? 7'd0 : 7'($urandom_range(1, 127));
        end
        base = 8'($urandom);
    endtask

    initial begin
        vld_s[0] = 0; vld_s[1] = 0;
        rdy_s[0] = 1; rdy_s[1] = 1;
        dbp = '0; dbx = '0; base = '0;
        repeat (2) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("reset_vld", vldo[s], 0);
            check("reset_rdy", rdyo[s], 0);
            check("reset_tok", tokv[s], '0);
        end
        @(negedge clk);
        rst_ni = 1'b1;

        rand_planes(100);
        run_block(0, 0, -1);
        for (int i = 0; i <= DW; i++) dbx[i] = 7'h01;
        run_block(0, 0, -1);
        dbx = '0;
        dbx[6] = 7'h05;
        run_block(0, 0, -1);
        rand_planes(100);
        run_block(1, 0, -1);
        rand_planes(0);
        run_block(0, 2, -1);
        rand_planes(0);
        run_block(0, 0, 4);
        run_block(0, 0, -1);

        for (int k = 0; k < 40; k++) begin
            rand_planes((k % 4 == 0) ? 90 : 60);
            run_block(k % 2, (k % 3 == 0) ? 1 : 0, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dbx_plane_sequencer.md
# dbx_plane_sequencer

Per-block plane scheduler for the EBPC encoder. It sits between the DBP/DBX holding buffer and the plane symbol encoder. It takes one held block of DATA_W+1 delta bit-planes and their XORed DBX planes, then emits a token stream: base value first, then planes from MSB (index DATA_W) down to 0, with consecutive all-zero DBX planes collapsed into zero-run tokens. When the last token of the block is accepted it returns a one-cycle done (rdy_o) to the buffer, which releases the block in place.

## Interface
- BLOCK_SIZE, 8, values per block; plane width is BLOCK_SIZE-1
- DATA_W, 32, data word width; there are DATA_W+1 planes per block
- MAX_ZRL, 16, maximum zero-run length per token (2..DATA_W+1)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- dbp_i  in  [BLOCK_SIZE-2:0] x [0:DATA_W]  held delta bit-planes
- dbx_i  in  [BLOCK_SIZE-2:0] x [0:DATA_W]  held DBX planes
- base_i  in  DATA_W  block base value
- vld_i  in  1  held block valid
- rdy_o  out  1  block done; one-cycle pulse when the final token handshakes
- tok_type_o  out  2  token type: BASE=0, ZRL=1, PLANE=2
- tok_base_o  out  DATA_W  base value (BASE tokens), else 0
- tok_dbx_o / tok_dbp_o  out  BLOCK_SIZE-1 each  plane contents (PLANE tokens), else 0
- tok_idx_o  out  $clog2(DATA_W+1)  plane index (PLANE tokens), else 0
- tok_len_o  out  $clog2(MAX_ZRL+1)  run length 1..MAX_ZRL (ZRL tokens), else 0
- tok_last_o  out  1  final token of the block
- vld_o  out  1  token valid
- rdy_i  in  1  downstream ready

## Operation
- Registers: state_q, idx_q (reset DATA_W), zrl_q (reset 0).
- IDLE: vld_o=0, all tok_* outputs 0. On vld_i, go to BASE.
- BASE: emit a BASE token (tok_base_o=base_i). On handshake, set idx_q=DATA_W and zrl_q=0, then go to SCAN.
- SCAN evaluates dbx_i[idx_q] each cycle:
  - Zero plane, zrl_q+1<MAX_ZRL, idx_q>0: no token. zrl_q++ and idx_q--.
  - Zero plane, and zrl_q+1==MAX_ZRL or idx_q==0: emit ZRL with len=zrl_q+1. On handshake, zrl_q=0 and idx_q--. If idx_q==0, the block is finished.
  - Nonzero plane, zrl_q>0: emit ZRL with len=zrl_q. On handshake, zrl_q=0. idx_q is unchanged, and the plane is re-evaluated next cycle.
  - Nonzero plane, zrl_q==0: emit PLANE (dbx, dbp, idx). On handshake, idx_q--. If idx_q==0, the block is finished.
- tok_last_o is 1 exactly on the token that finishes the block.
- On a handshake with tok_last_o=1:
  - rdy_o=1, combinational, in that same cycle.
  - Go to IDLE. There is one bubble cycle before the next block's BASE token.
- The dbp_i/dbx_i/base_i values are never registered. The upstream block holds them stable while vld_i=1 and until rdy_o.
- If vld_i drops mid-block, that is a protocol violation. The sequencer does not check for it.

## Timing
- Reset:
  - State IDLE, idx_q=DATA_W, zrl_q=0.
  - vld_o=0, rdy_o=0, all tok_* outputs 0.
- Reset asserted mid-block returns to IDLE immediately. The first cycle after release has vld_o=0.
- Latency:
  - vld_i rising in IDLE at cycle 0 gives the BASE token at cycle 1.
  - The first SCAN evaluation is in the cycle after the BASE handshake.
- Throughput: one plane per cycle with rdy_i=1.
  - ZRL splits before a nonzero plane cost one extra cycle.
  - A block of all nonzero planes takes DATA_W+3 cycles, counting from BASE through the IDLE bubble.
- Handshake:
  - A token transfers on vld_o&rdy_i.
  - While vld_o=1 and rdy_i=0, all tok_* outputs and state are held stable. A token is never retracted.
- Accumulate cycles (no token) advance regardless of rdy_i.
- Width rule: len never exceeds MAX_ZRL and is never 0. idx_q does not wrap, because it leaves SCAN at 0.

## Structure
- Shared package ebpc_pkg:
  - tok_type_e (BASE, ZRL, PLANE)
  - state enum (IDLE, BASE, SCAN)
  - localparams IDX_W=$clog2(DATA_W+1) and LEN_W=$clog2(MAX_ZRL+1)
- Single module. The zero-plane test is a reduction OR on dbx_i[idx_q], and no sub-module is warranted.

## Test plan
All scenarios use DATA_W=8, BLOCK_SIZE=8 and rdy_i=1 unless stated.
- All dbx planes 0, MAX_ZRL=16 -> BASE, then ZRL len=9 with last=1; rdy_o pulses once.
- All dbx planes 7'h01 -> BASE, then 9 PLANE tokens idx 8..0 with last only on idx 0; 11 cycles from vld_i to the next IDLE.
- dbx[8]=dbx[7]=0, dbx[6]=7'h05, rest 0 -> BASE, ZRL len=2, PLANE idx=6 dbx=7'h05, ZRL len=6 last.
- MAX_ZRL=4, all planes 0 -> BASE, ZRL 4, ZRL 4, ZRL 1 last.
- PLANE idx=5 token with rdy_i held low for 3 cycles -> all tok_* outputs stable for 4 cycles, and idx advances only after the handshake.
- Assert rst_ni during SCAN at idx=4 with vld_i still high -> vld_o=0 during reset; after release, BASE restarts the block and no rdy_o pulse is produced for the aborted pass.
